// File: rtl/bus_arbiter_b16.sv
// Round-robin owner arbiter for the shared 16-bit bus: one-hot tristate
// enables, bounded hold time with forced release, and a fixed dead time
// between bus owners so two tristate drivers never overlap.
module bus_arbiter_b16 #(
  parameter int unsigned MAX_HOLD   = 8,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  output logic [3:0] SEL,
  output logic [1:0] OWNER,
  output logic       BUSY,
  output logic       PREEMPT
);

  localparam int unsigned NREQ   = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned TURN_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NREQ-1:0]     sel_q, sel_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic                busy_q, busy_d;
  logic                preempt_q, preempt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TURN_W-1:0]   turn_q, turn_d;

  logic                rr_found;
  logic [IDX_W-1:0]    rr_winner;
  logic                others_req;
  logic                hold_max;
  logic                turn_last;

  // Round-robin search beginning one past the most recent owner
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = owner_q;
    for (int k = 1; k <= 4; k++) begin
      if (!rr_found && REQ[owner_q + IDX_W'(k)]) begin
        rr_found  = 1'b1;
        rr_winner = owner_q + IDX_W'(k);
      end
    end
  end

  assign others_req = |(REQ & ~(NREQ'(1) << owner_q));
  assign hold_max   = (hold_q == HOLD_W'(MAX_HOLD));
  assign turn_last  = (turn_q == TURN_W'(TURNAROUND));

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    preempt_d = 1'b0;
    hold_d    = hold_q;
    turn_d    = turn_q;

    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          state_d = ST_GRANT;
          sel_d   = NREQ'(1) << rr_winner;
          owner_d = rr_winner;
          busy_d  = 1'b1;
          hold_d  = HOLD_W'(1);
        end
      end

      ST_GRANT: begin
        if (!REQ[owner_q] || (hold_max && others_req)) begin
          // Release: either voluntary or forced after the hold limit
          state_d   = ST_TURN;
          sel_d     = '0;
          busy_d    = 1'b0;
          hold_d    = '0;
          turn_d    = TURN_W'(1);
          preempt_d = REQ[owner_q];
        end else if (!hold_max) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      ST_TURN: begin
        if (turn_last) begin
          turn_d = '0;
          if (rr_found) begin
            state_d = ST_GRANT;
            sel_d   = NREQ'(1) << rr_winner;
            owner_d = rr_winner;
            busy_d  = 1'b1;
            hold_d  = HOLD_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
        busy_d  = 1'b0;
        hold_d  = '0;
        turn_d  = '0;
      end
    endcase
  end

  // State and output registers; reset drops the bus immediately
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      owner_q   <= IDX_W'(3);
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      hold_q    <= '0;
      turn_q    <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
      hold_q    <= hold_d;
      turn_q    <= turn_d;
    end
  end

  assign SEL     = sel_q;
  assign OWNER   = owner_q;
  assign BUSY    = busy_q;
  assign PREEMPT = preempt_q;

endmodule

// File: tb/tb_bus_arbiter_b16.sv
// Bench for bus_arbiter_b16: two parameterisations driven by the same REQ,
// directed scenarios plus a long random run against a behavioural model.
module tb_bus_arbiter_b16;

  localparam int MH_A = 4;
  localparam int T_A  = 1;
  localparam int MH_B = 3;
  localparam int T_B  = 3;

  localparam int PH_IDLE  = 0;
  localparam int PH_GRANT = 1;
  localparam int PH_TURN  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] sel_a, sel_b;
  logic [1:0] own_a, own_b;
  logic       busy_a, busy_b, pre_a, pre_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_arbiter_b16 #(.MAX_HOLD(MH_A), .TURNAROUND(T_A)) dut_a (
    .CLK(clk), .RST(rst), .REQ(req),
    .SEL(sel_a), .OWNER(own_a), .BUSY(busy_a), .PREEMPT(pre_a)
  );

  bus_arbiter_b16 #(.MAX_HOLD(MH_B), .TURNAROUND(T_B)) dut_b (
    .CLK(clk), .RST(rst), .REQ(req),
    .SEL(sel_b), .OWNER(own_b), .BUSY(busy_b), .PREEMPT(pre_b)
  );

  // Behavioural reference: phase, owner, cycles held, turn cycles remaining
  int m_phase[2];
  int m_owner[2];
  int m_held[2];
  int m_left[2];
  bit m_pre[2];

  function automatic int mh(int k);
    return (k == 0) ? MH_A : MH_B;
  endfunction

  function automatic int tp(int k);
    return (k == 0) ? T_A : T_B;
  endfunction

  function automatic int rr_pick(int last, logic [3:0] r);
    for (int i = 1; i <= 4; i++) begin
      if (r[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_sel(int k);
    logic [3:0] one;
    one = 4'b0001;
    return (m_phase[k] == PH_GRANT) ? (one << m_owner[k]) : 4'b0000;
  endfunction

  always @(posedge clk) begin : model_step
    int w;
    for (int k = 0; k < 2; k++) begin
      m_pre[k] = 1'b0;
      if (rst) begin
        m_phase[k] = PH_IDLE;
        m_owner[k] = 3;
        m_held[k]  = 0;
        m_left[k]  = 0;
      end else begin
        case (m_phase[k])
          PH_IDLE: begin
            w = rr_pick(m_owner[k], req);
            if (w >= 0) begin
              m_phase[k] = PH_GRANT; m_owner[k] = w; m_held[k] = 1;
            end
          end
          PH_GRANT: begin
            if (!req[m_owner[k]]) begin
              m_phase[k] = PH_TURN; m_left[k] = tp(k);
            end else if (m_held[k] == mh(k) && rr_pick(m_owner[k], req) != m_owner[k]) begin
              m_phase[k] = PH_TURN; m_left[k] = tp(k); m_pre[k] = 1'b1;
            end else if (m_held[k] < mh(k)) begin
              m_held[k]++;
            end
          end
          default: begin
            if (m_left[k] > 1) begin
              m_left[k]--;
            end else begin
              w = rr_pick(m_owner[k], req);
              if (w >= 0) begin
                m_phase[k] = PH_GRANT; m_owner[k] = w; m_held[k] = 1;
              end else begin
                m_phase[k] = PH_IDLE;
              end
            end
          end
        endcase
      end
    end
  end

  // Hold reset for two edges, release at a falling edge (caller then sets REQ)
  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    repeat (3) @(negedge clk);
    checks++;
    if ({sel_a, own_a, busy_a, pre_a} !== {4'b0000, 2'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_a sel=%b owner=%0d busy=%b pre=%b expected 0000/3/0/0", sel_a, own_a, busy_a, pre_a);
    end
    checks++;
    if ({sel_b, own_b, busy_b, pre_b} !== {4'b0000, 2'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_b sel=%b owner=%0d busy=%b pre=%b expected 0000/3/0/0", sel_b, own_b, busy_b, pre_b);
    end
  endtask

  task automatic test_single_hold();
    do_reset();
    req = 4'b0001;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if ({sel_a, own_a, busy_a, pre_a} !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL hold_a cyc %0d sel=%b owner=%0d busy=%b pre=%b expected 0001/0/1/0", i, sel_a, own_a, busy_a, pre_a);
      end
      checks++;
      if ({sel_b, own_b, busy_b, pre_b} !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL hold_b cyc %0d sel=%b owner=%0d busy=%b pre=%b expected 0001/0/1/0", i, sel_b, own_b, busy_b, pre_b);
      end
    end
  endtask

  task automatic test_preempt();
    logic [3:0] esa [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010};
    logic       epa [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] eoa [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    logic [3:0] esb [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
    logic       epb [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] eob [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if ({sel_a, pre_a, own_a, busy_a} !== {esa[i], epa[i], eoa[i], |esa[i]}) begin
        errors++;
        $display("FAIL preempt_a cyc %0d sel=%b pre=%b owner=%0d busy=%b expected %b/%b/%0d/%b",
                 i + 1, sel_a, pre_a, own_a, busy_a, esa[i], epa[i], eoa[i], |esa[i]);
      end
      checks++;
      if ({sel_b, pre_b, own_b, busy_b} !== {esb[i], epb[i], eob[i], |esb[i]}) begin
        errors++;
        $display("FAIL preempt_b cyc %0d sel=%b pre=%b owner=%0d busy=%b expected %b/%b/%0d/%b",
                 i + 1, sel_b, pre_b, own_b, busy_b, esb[i], epb[i], eob[i], |esb[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] one;
    logic [3:0] exp;
    one = 4'b0001;
    do_reset();
    req = 4'b1111;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      exp = (i % 2 == 1) ? (one << (((i - 1) / 2) % 4)) : 4'b0000;
      checks++;
      if (sel_a !== exp || busy_a !== |exp) begin
        errors++;
        $display("FAIL rr_order cyc %0d sel=%b busy=%b expected %b/%b", i, sel_a, busy_a, exp, |exp);
      end
      req = 4'b1111 & ~exp;
    end
  endtask

  task automatic test_turnaround();
    logic [3:0] exps [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001};
    logic [1:0] expo [4] = '{2'd2, 2'd2, 2'd2, 2'd0};
    logic [3:0] drv  [4] = '{4'b1000, 4'b0001, 4'b0001, 4'b0001};
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (sel_b !== 4'b0100) begin
      errors++;
      $display("FAIL turn_grant sel=%b expected 0100", sel_b);
    end
    req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (sel_b !== exps[i] || own_b !== expo[i]) begin
        errors++;
        $display("FAIL turn_gap t+%0d sel=%b owner=%0d expected %b/%0d", i + 1, sel_b, own_b, exps[i], expo[i]);
      end
      req = drv[i];
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0100;
    repeat (2) @(negedge clk);
    checks++;
    if (sel_a !== 4'b0100) begin
      errors++;
      $display("FAIL rst_mid_pre sel=%b expected 0100", sel_a);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({sel_a, own_a, busy_a, sel_b, own_b, busy_b} !== {4'b0000, 2'd3, 1'b0, 4'b0000, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_drop sel_a=%b own_a=%0d sel_b=%b own_b=%0d expected 0000/3 both", sel_a, own_a, sel_b, own_b);
    end
    rst = 1'b0;
    req = 4'b1100;
    @(negedge clk);
    checks++;
    if ({sel_a, own_a, sel_b, own_b} !== {4'b0100, 2'd2, 4'b0100, 2'd2}) begin
      errors++;
      $display("FAIL rst_mid_resume sel_a=%b own_a=%0d sel_b=%b own_b=%0d expected 0100/2 both", sel_a, own_a, sel_b, own_b);
    end
  endtask

  task automatic test_random();
    logic [3:0] dsel [2];
    logic [1:0] down [2];
    logic       dbusy [2];
    logic       dpre [2];
    logic [3:0] es;
    int         last_o [2];
    int         zeros [2];
    int         wait_c [2][4];
    int         o;
    do_reset();
    req = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      last_o[k] = -1;
      zeros[k]  = 0;
      for (int i = 0; i < 4; i++) wait_c[k][i] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      dsel[0] = sel_a;  down[0] = own_a;  dbusy[0] = busy_a;  dpre[0] = pre_a;
      dsel[1] = sel_b;  down[1] = own_b;  dbusy[1] = busy_b;  dpre[1] = pre_b;
      for (int k = 0; k < 2; k++) begin
        es = m_sel(k);
        checks++;
        if (dsel[k] !== es || down[k] !== 2'(m_owner[k]) || dbusy[k] !== (m_phase[k] == PH_GRANT) || dpre[k] !== m_pre[k]) begin
          errors++;
          $display("FAIL rand_model inst %0d cyc %0d sel=%b own=%0d busy=%b pre=%b expected %b/%0d/%b/%b",
                   k, c, dsel[k], down[k], dbusy[k], dpre[k], es, m_owner[k], m_phase[k] == PH_GRANT, m_pre[k]);
        end
        checks++;
        if (!$onehot0(dsel[k])) begin
          errors++;
          $display("FAIL rand_onehot inst %0d cyc %0d sel=%b expected at most one bit", k, c, dsel[k]);
        end
        if (rst) begin
          last_o[k] = -1;
          zeros[k]  = 0;
          for (int i = 0; i < 4; i++) wait_c[k][i] = 0;
        end else begin
          if (dsel[k] != 4'b0000) begin
            o = 0;
            for (int i = 0; i < 4; i++) if (dsel[k][i]) o = i;
            if (last_o[k] >= 0 && o != last_o[k]) begin
              checks++;
              if (zeros[k] < tp(k)) begin
                errors++;
                $display("FAIL rand_gap inst %0d cyc %0d gap=%0d expected >= %0d", k, c, zeros[k], tp(k));
              end
            end
            last_o[k] = o;
            zeros[k]  = 0;
          end else begin
            zeros[k]++;
          end
          for (int i = 0; i < 4; i++) begin
            if (req[i] && !dsel[k][i]) begin
              wait_c[k][i]++;
              checks++;
              if (wait_c[k][i] > 3 * (mh(k) + tp(k) + 1)) begin
                errors++;
                $display("FAIL rand_starve inst %0d req %0d cyc %0d waited=%0d expected <= %0d",
                         k, i, c, wait_c[k][i], 3 * (mh(k) + tp(k) + 1));
              end
            end else begin
              wait_c[k][i] = 0;
            end
          end
        end
      end
      // Requesters hold until served, then release after a random while
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if ((m_sel(0)[i] || m_sel(1)[i]) && $urandom_range(0, 5) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
        end
      end
      rst = ($urandom_range(0, 999) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    test_reset();
    test_single_hold();
    test_preempt();
    test_round_robin();
    test_turnaround();
    test_reset_mid_grant();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
